md_unit: RTL and testbench

- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. Sits beside the ALU.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and holds the architectural HI/LO registers.
- Serves mthi/mtlo writes. Drives high/low to the writeback-side mux that resolves mfhi/mflo.
- Exposes start/busy so the hazard unit can stall any MD instruction that sits in D while the unit is occupied.

---
 rtl/md_defs.sv | 21 ++
 rtl/md_calc.sv | 62 ++++++
 rtl/md_unit.sv | 112 +++++++++++
 tb/tb_md_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared encodings for the multiply/divide unit, also used by the controller
// and hazard unit, plus the default busy latencies.
package md_defs;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_t;

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply and 32/32 divide for the MD unit. Results are
// produced in HI/LO form; div_zero flags a divide whose result must be dropped.
module md_calc
    import md_defs::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        is_signed_div;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Divide on magnitudes so the 0x80000000 / -1 case falls out naturally
    // (quotient magnitude 0x80000000, remainder 0) and b=0 never reaches '/'.
    assign is_signed_div = (md_op == MD_DIV);
    assign b_safe        = (b == 32'd0) ? 32'd1 : b;
    assign a_mag         = (is_signed_div && a[31]) ? -a : a;
    assign b_mag         = (is_signed_div && b_safe[31]) ? -b_safe : b_safe;
    assign q_mag         = a_mag / b_mag;
    assign r_mag         = a_mag % b_mag;

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        div_zero = 1'b0;
        case (md_op)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_lo   = (a[31] ^ b[31]) ? -q_mag : q_mag;
                res_hi   = a[31] ? -r_mag : r_mag;
                div_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                res_lo   = q_mag;
                res_hi   = r_mag;
                div_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/div with HI/LO commit,
// plus single-cycle mthi/mtlo. busy lets the hazard unit stall MD instructions.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] high,
    output logic [31:0] low
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    md_state_t   state_reg;
    md_state_t   state_next;
    logic [3:0]  count_reg;
    logic [3:0]  count_next;
    logic [31:0] pend_hi_reg;
    logic [31:0] pend_lo_reg;
    logic        pend_ok_reg;
    logic [31:0] high_reg;
    logic [31:0] low_reg;

    logic        launch;
    logic        commit;
    logic        is_md;
    logic        is_div;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_dz;

    md_calc u_calc (
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .res_hi   (calc_hi),
        .res_lo   (calc_lo),
        .div_zero (calc_dz)
    );

    assign is_md  = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                    (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign is_div = (md_op == MD_DIV)  || (md_op == MD_DIVU);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        launch     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && is_md) begin
                    launch     = 1'b1;
                    state_next = ST_RUN;
                    count_next = is_div ? DIV_N : MULT_N;
                end
            end
            ST_RUN: begin
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    commit     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            count_reg   <= 4'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_ok_reg <= 1'b0;
            high_reg    <= 32'd0;
            low_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (launch) begin
                pend_hi_reg <= calc_hi;
                pend_lo_reg <= calc_lo;
                pend_ok_reg <= !calc_dz;
            end
            // mthi/mtlo only land while idle; the commit edge still counts as busy.
            if (commit) begin
                if (pend_ok_reg) begin
                    high_reg <= pend_hi_reg;
                    low_reg  <= pend_lo_reg;
                end
            end else if (state_reg == ST_IDLE && !start) begin
                if (md_op == MD_MTHI) high_reg <= a;
                if (md_op == MD_MTLO) low_reg  <= a;
            end
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign high = high_reg;
    assign low  = low_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed table, randomized ops against a
// 64-bit arithmetic model, and hand sequences for same-edge and reset cases.
module tb_md_unit;
    import md_defs::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = MD_NONE;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic [31:0] high;
    logic [31:0] low;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .md_op   (md_op),
        .a       (op_a),
        .b       (op_b),
        .busy    (busy),
        .high    (high),
        .low     (low)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  inout logic [31:0] mh, inout logic [31:0] ml);
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint unsigned ux = {32'd0, x};
        longint unsigned uy = {32'd0, y};
        logic [63:0]     p;
        logic [63:0]     r;
        case (op)
            MD_MULT:  begin p = sx * sy; mh = p[63:32]; ml = p[31:0]; end
            MD_MULTU: begin p = ux * uy; mh = p[63:32]; ml = p[31:0]; end
            MD_DIV: if (y != 0) begin
                p = sx / sy; r = sx % sy; ml = p[31:0]; mh = r[31:0];
            end
            MD_DIVU: if (y != 0) begin
                ml = x / y; mh = x % y;
            end
            default: ;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op);
        return (op == MD_DIV || op == MD_DIVU) ? DIV_N : MULT_N;
    endfunction

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        md_op = op; op_a = v; start = 1'b0;
        @(negedge clk);
        md_op = MD_NONE;
        $display("[TB] %s 0x%08h -> hi=0x%08h lo=0x%08h", (op == MD_MTHI) ? "mthi" : "mtlo", v, high, low);
    endtask

    // Launch op, then watch busy; optional injections at busy-sample index c1/c2.
    task automatic launch_watch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] old_hi, input logic [31:0] old_lo,
                                input int c1, input logic s1, input logic [2:0] o1,
                                input logic [31:0] a1, input logic [31:0] b1,
                                input int c2, input logic s2, input logic [2:0] o2,
                                input logic [31:0] a2, input logic [31:0] b2,
                                output int cyc, output bit held);
        cyc  = 0;
        held = 1'b1;
        @(negedge clk);
        start = 1'b1; md_op = op; op_a = x; op_b = y;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        while (busy === 1'b1 && cyc < 20) begin
            cyc++;
            if (high !== old_hi || low !== old_lo) held = 1'b0;
            start = 1'b0; md_op = MD_NONE;
            if (cyc == c1) begin start = s1; md_op = o1; op_a = a1; op_b = b1; end
            if (cyc == c2) begin start = s2; md_op = o2; op_a = a2; op_b = b2; end
            @(negedge clk);
        end
        start = 1'b0; md_op = MD_NONE;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] old_hi, input logic [31:0] old_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        bit held;
        launch_watch(op, x, y, old_hi, old_lo, 0, 1'b0, MD_NONE, 0, 0, 0, 1'b0, MD_NONE, 0, 0, cyc, held);
        $display("[TB] %s op=%0d a=0x%08h b=0x%08h busy=%0d hi=0x%08h lo=0x%08h", name, op, x, y, cyc, high, low);
        check({name, " busy_cycles"}, 32'(cyc), 32'(lat(op)));
        check({name, " hold"}, {31'd0, held}, 32'd1);
        check({name, " hi"}, high, exp_hi);
        check({name, " lo"}, low, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[8];
        logic [31:0] mh, ml, ph, pl;
        logic [2:0]  rop;
        logic [31:0] rx, ry;
        int          cyc;
        bit          held, quiet;

        vecs[0] = '{"mult_neg",   MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{"multu_max",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{"div_neg",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"div_ovf",    MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{"divu_zero",  MD_DIVU,  32'd7,         32'd0,         32'h0000_0011, 32'h0000_0022};
        vecs[5] = '{"div_zero",   MD_DIV,   32'd7,         32'd0,         32'h0000_0011, 32'h0000_0022};
        vecs[6] = '{"divu_big",   MD_DIVU,  32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
        vecs[7] = '{"div_negdiv", MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset high", high, 32'd0);
        check("reset low", low, 32'd0);
        reset_n = 1'b1;

        // Directed table, each from a known HI/LO preload
        for (int i = 0; i < 8; i++) begin
            mt(MD_MTHI, 32'h11);
            mt(MD_MTLO, 32'h22);
            check({vecs[i].name, " preload_hi"}, high, 32'h11);
            check({vecs[i].name, " preload_lo"}, low, 32'h22);
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 32'h11, 32'h22, vecs[i].hi, vecs[i].lo);
        end

        // Randomized ops against the model
        mh = 32'hA5A5_0001;
        ml = 32'h5A5A_0002;
        mt(MD_MTHI, mh);
        mt(MD_MTLO, ml);
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(1, 4));
            rx  = $urandom;
            ry  = $urandom;
            case ($urandom_range(0, 5))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 15));
                2: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
                default: ;
            endcase
            ph = mh; pl = ml;
            model(rop, rx, ry, mh, ml);
            run_op("rand", rop, rx, ry, ph, pl, mh, ml);
        end

        // mthi and start while a div runs are both ignored
        ph = mh; pl = ml;
        launch_watch(MD_DIV, 32'd100, 32'd7, ph, pl,
                     3, 1'b0, MD_MTHI, 32'h1234, 32'd0,
                     5, 1'b1, MD_MULT, 32'd2, 32'd3, cyc, held);
        $display("[TB] div 100/7 with mid-run mthi/start busy=%0d hi=0x%08h lo=0x%08h", cyc, high, low);
        check("midrun busy_cycles", 32'(cyc), 32'(DIV_N));
        check("midrun hold", {31'd0, held}, 32'd1);
        check("midrun hi", high, 32'd2);
        check("midrun lo", low, 32'd14);
        mt(MD_MTHI, 32'h1234);
        check("after_busy mthi", high, 32'h1234);
        run_op("after_busy mult", MD_MULT, 32'd2, 32'd3, 32'h1234, 32'd14, 32'd0, 32'd6);

        // start on the commit edge is ignored
        launch_watch(MD_MULT, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd6,
                     MULT_N, 1'b1, MD_DIVU, 32'd9, 32'd2,
                     0, 1'b0, MD_NONE, 32'd0, 32'd0, cyc, held);
        $display("[TB] mult -1*3 with start on commit edge busy=%0d hi=0x%08h lo=0x%08h", cyc, high, low);
        check("edge_start busy_cycles", 32'(cyc), 32'(MULT_N));
        check("edge_start busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("edge_start still_idle", {31'd0, busy}, 32'd0);
        check("edge_start hi", high, 32'hFFFF_FFFF);
        check("edge_start lo", low, 32'hFFFF_FFFD);

        // mthi on the commit edge is ignored, next cycle accepted
        launch_watch(MD_MULT, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                     MULT_N, 1'b0, MD_MTHI, 32'h5555, 32'd0,
                     0, 1'b0, MD_NONE, 32'd0, 32'd0, cyc, held);
        $display("[TB] mult 2^16*2^16 with mthi on commit edge busy=%0d hi=0x%08h lo=0x%08h", cyc, high, low);
        check("edge_mthi hold", {31'd0, held}, 32'd1);
        check("edge_mthi hi", high, 32'd1);
        check("edge_mthi lo", low, 32'd0);
        mt(MD_MTHI, 32'h5555);
        check("edge_mthi next_cycle", high, 32'h5555);

        // Asynchronous reset mid-operation discards the pending result
        mt(MD_MTHI, 32'hDEAD);
        mt(MD_MTLO, 32'hBEEF);
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; op_a = 32'd3; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        check("rst busy_before", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        $display("[TB] async reset mid-mult busy=%0d hi=0x%08h lo=0x%08h", busy, high, low);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst high", high, 32'd0);
        check("rst low", low, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0) quiet = 1'b0;
        end
        check("rst no_busy_after", {31'd0, quiet}, 32'd1);
        check("rst no_commit_hi", high, 32'd0);
        check("rst no_commit_lo", low, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
